// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmit FSM states and queue depths.
package mmio_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int STATUS_FULL = 0;
  localparam int STATUS_BUSY = 1;
  localparam int STATUS_OVF  = 2;

  localparam int FIFO_DEPTH = 4;
  localparam int HOLD_DEPTH = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO: registered write, combinational head output, zero-latency pop.
// A push while full is accepted only when a pop frees an entry on the same edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter (TXDATA/STATUS window, 8N1); txd falls one edge after a store to an idle, empty queue.
// Stores to a full queue are dropped and set sticky overflow; MMIO_UART_TX_FIFO_EN selects a 4-deep FIFO over a 1-entry holding register.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic        hit,
  output logic [31:0] rdata,
  output logic        txd
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  tx_state_t   state;
  tx_state_t   state_nxt;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        txd_nxt;
  logic        baud_end;
  logic        bit_last;
  logic        sel_tx;
  logic        sel_st;
  logic        push;
  logic        pop;
  logic        ovf_clr;
  logic        overflow;
  logic        busy;
  logic [7:0]  q_dat;
  logic        q_full;
  logic        q_empty;
  logic        unused_wd;

  assign sel_tx    = (adr == BASE_ADDR + TXDATA_OFS);
  assign sel_st    = (adr == BASE_ADDR + STATUS_OFS);
  assign hit       = sel_tx || sel_st;
  assign push      = memwrite && sel_tx;
  assign ovf_clr   = memwrite && sel_st && writedata[STATUS_OVF];
  assign unused_wd = ^writedata[31:8];

`ifdef MMIO_UART_TX_FIFO_EN
  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (writedata[7:0]),
    .pop   (pop),
    .dout  (q_dat),
    .full  (q_full),
    .empty (q_empty)
  );
`else
  logic       hold_vld;
  logic [7:0] hold_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld <= 1'b0;
      hold_dat <= '0;
    end else if (push && (!hold_vld || pop)) begin
      hold_vld <= 1'b1;
      hold_dat <= writedata[7:0];
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end

  assign q_dat   = hold_dat;
  assign q_full  = hold_vld;
  assign q_empty = !hold_vld;
`endif

  // A pop on the same edge frees the slot, so only an unmatched push overflows.
  always_ff @(posedge clk) begin
    if (reset)                          overflow <= 1'b0;
    else if (push && q_full && !pop)    overflow <= 1'b1;
    else if (ovf_clr)                   overflow <= 1'b0;
  end

  assign busy  = (state != IDLE) || !q_empty;
  assign rdata = sel_st ? {29'b0, overflow, busy, q_full} : 32'h0;

  assign baud_end = (baud_cnt == BAUD_MAX);
  assign bit_last = (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!q_empty)             state_nxt = START;
      START: if (baud_end)             state_nxt = DATA;
      DATA:  if (baud_end && bit_last) state_nxt = STOP;
      STOP:  if (baud_end)             state_nxt = q_empty ? IDLE : START;
    endcase
  end

  // txd is registered, so each branch chooses the level for the next bit slot.
  always_comb begin
    pop     = 1'b0;
    txd_nxt = txd;
    case (state)
      IDLE: begin
        txd_nxt = q_empty;
        pop     = !q_empty;
      end
      START: if (baud_end) txd_nxt = shreg[0];
      DATA:  if (baud_end) txd_nxt = bit_last ? 1'b1 : shreg[1];
      STOP: begin
        if (baud_end && !q_empty) begin
          pop     = 1'b1;
          txd_nxt = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      txd      <= txd_nxt;
      baud_cnt <= (state == IDLE || baud_end) ? 16'd0 : baud_cnt + 16'd1;
      if (pop)
        shreg <= q_dat;
      else if (state == DATA && baud_end)
        shreg <= shreg >> 1;
      if (state == DATA && baud_end)
        bit_cnt <= bit_last ? 3'd0 : bit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a line monitor decodes frames at mid-bit and checks them against a byte scoreboard.
module tb_mmio_uart_tx;

  localparam int          C    = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
`ifdef MMIO_UART_TX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic        hit;
  logic [31:0] rdata;
  logic        txd;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  int         starts[$];
  int         cyc = 0;
  int         t = 0;
  int         bit_idx;
  bit         in_frame = 1'b0;
  logic [7:0] rx;
  logic [7:0] b;

  mmio_uart_tx #(
    .CLKS_PER_BIT (C),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .hit       (hit),
    .rdata     (rdata),
    .txd       (txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input logic [31:0] exp, input string tag);
    adr      = BASE + 32'h4;
    memwrite = 1'b0;
    #1;
    check({tag, "_hit"}, 32'(hit), 32'h1);
    check(tag, rdata, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    adr       = a;
    writedata = d;
    memwrite  = 1'b1;
    @(negedge clk);
    memwrite  = 1'b0;
  endtask

  task automatic expect_idle_line(input int n, input string tag);
    int lows;
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check(tag, 32'(lows), 32'h0);
  endtask

  // Frame decoder: t counts negedges from the first low sample; bit k is sampled mid-slot.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (txd === 1'b0) begin
        in_frame = 1'b1;
        t = 0;
        starts.push_back(cyc);
      end
    end else begin
      t++;
    end
    if (in_frame && (t % C) == C / 2) begin
      bit_idx = t / C;
      if (bit_idx == 0) begin
        check("start_bit", 32'(txd), 32'h0);
      end else if (bit_idx <= 8) begin
        rx[bit_idx-1] = txd;
      end else begin
        check("stop_bit", 32'(txd), 32'h1);
        check("frame_expected", 32'(sb.size() != 0), 32'h1);
        if (sb.size() != 0) check("rx_byte", 32'(rx), 32'(sb.pop_front()));
      end
    end
    if (in_frame && t == 10 * C - 1) in_frame = 1'b0;
  end

  initial begin
    reset     = 1'b1;
    adr       = 32'h0;
    writedata = 32'h0;
    memwrite  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_txd", 32'(txd), 32'h1);
    check_status(32'h0, "reset_status");

    // Single frame 0xA5: latency, busy duration, bit order via the decoder.
    @(negedge clk);
    store(BASE, 32'h0000_00A5);
    sb.push_back(8'hA5);
    check("txd_before_edge1", 32'(txd), 32'h1);
    @(negedge clk);
    check("txd_low_edge1", 32'(txd), 32'h0);
    check_status(32'h2, "busy_in_frame");
    repeat (39) @(negedge clk);
    check_status(32'h2, "busy_edge40");
    @(negedge clk);
    check_status(32'h0, "idle_edge41");
    check("sb_drained_a5", 32'(sb.size()), 32'h0);

    // Back-to-back stores: second start directly follows first stop.
    repeat (5) @(negedge clk);
    starts.delete();
    store(BASE, 32'h0000_0055);
    sb.push_back(8'h55);
    store(BASE, 32'h0000_00AA);
    sb.push_back(8'hAA);
    repeat (90) @(negedge clk);
    check("frame_count", 32'(starts.size()), 32'h2);
    if (starts.size() == 2) check("frame_gap", 32'(starts[1] - starts[0]), 32'(10 * C));
    check("sb_drained_55aa", 32'(sb.size()), 32'h0);
    check_status(32'h0, "idle_after_pair");

    // Overrun: DEPTH+1 stores fit (one is popped at once), the next is dropped.
    @(negedge clk);
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'h30 + 8'(i);
      store(BASE, {24'hC0FFEE, b});
      if (i <= DEPTH) sb.push_back(b);
      if (i == DEPTH) check_status(32'h3, "full_no_ovf");
    end
    check_status(32'h7, "full_ovf");
    store(BASE + 32'h4, 32'h0000_0004);
    check_status(32'h3, "ovf_cleared");
    repeat ((DEPTH + 1) * 10 * C + 20) @(negedge clk);
    check("sb_drained_burst", 32'(sb.size()), 32'h0);
    check_status(32'h0, "idle_after_burst");

    // Reset in DATA with a byte queued behind it.
    @(negedge clk);
    store(BASE, 32'h0000_003C);
    sb.push_back(8'h3C);
    store(BASE, 32'h0000_00C3);
    sb.push_back(8'hC3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("txd_after_reset", 32'(txd), 32'h1);
    check_status(32'h0, "status_in_reset");
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    expect_idle_line(100, "no_frame_after_reset");
    check_status(32'h0, "status_after_reset");

    // Address decode and stores outside the window.
    adr = 32'h0000_0040;
    #1;
    check("miss_hit", 32'(hit), 32'h0);
    check("miss_rdata", rdata, 32'h0);
    adr = BASE;
    #1;
    check("txdata_hit", 32'(hit), 32'h1);
    check("txdata_rdata", rdata, 32'h0);
    adr = BASE + 32'h8;
    #1;
    check("above_window_hit", 32'(hit), 32'h0);
    @(negedge clk);
    store(32'h0000_0040, 32'h0000_00FF);
    store(BASE + 32'h8, 32'h0000_0012);
    expect_idle_line(20, "no_frame_outside_window");
    check_status(32'h0, "status_outside_window");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
